// File: rtl/img_ram_pkg.sv
// Shared types and constants for the image RAM arbiter/sequencer.
// The IMG_RAM_SKID_EN build option is implemented in img_ram_ctrl.sv and img_wr_skid.sv.
package img_ram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;
    localparam int   RD_LATENCY = 2;

endpackage

// File: rtl/img_wr_skid.sv
// One-entry write holding buffer with flush; used only when IMG_RAM_SKID_EN is defined.
module img_wr_skid #(
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic [DataWidth-1:0] data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/img_ram_ctrl.sv
// Single-port image RAM arbiter: reader has strict priority over the auto-addressed frame writer.
// Define IMG_RAM_SKID_EN to decouple wr_ready from rd_req through a one-entry write buffer.
module img_ram_ctrl
    import img_ram_pkg::*;
#(
    parameter int AddressWidth = 14,
    parameter int DataWidth    = 8,
    parameter int NumPixels    = 16384
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    wr_valid,
    input  logic [DataWidth-1:0]    wr_data,
    output logic                    wr_ready,
    input  logic                    rd_req,
    input  logic [AddressWidth-1:0] rd_addr,
    output logic                    rd_valid,
    output logic [DataWidth-1:0]    rd_data,
    output logic                    ram_rw,
    output logic [AddressWidth-1:0] ram_addr,
    output logic [DataWidth-1:0]    ram_din,
    input  logic [DataWidth-1:0]    ram_dout,
    output logic                    busy,
    output logic                    done
);

    localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(NumPixels - 1);

    state_t                  state_reg, state_next;
    logic [AddressWidth-1:0] wr_addr_reg;
    logic                    wr_go;
    logic [DataWidth-1:0]    wr_go_data;
    logic                    wr_last;
    logic [RD_LATENCY-1:0]   rd_pipe_reg;

    assign busy    = (state_reg == ST_LOAD);
    assign wr_last = (wr_addr_reg == LAST_ADDR);

`ifdef IMG_RAM_SKID_EN
    logic                 skid_valid;
    logic [DataWidth-1:0] skid_data;
    logic                 skid_push;

    assign wr_ready   = busy & ~skid_valid & ~start;
    assign skid_push  = wr_valid & wr_ready;
    // The buffered beat drains only on a cycle the reader leaves free; start discards it.
    assign wr_go      = skid_valid & ~rd_req & ~start;
    assign wr_go_data = skid_data;

    img_wr_skid #(
        .DataWidth(DataWidth)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (start),
        .push     (skid_push),
        .push_data(wr_data),
        .pop      (wr_go),
        .valid    (skid_valid),
        .data     (skid_data)
    );
`else
    assign wr_ready   = busy & ~rd_req & ~start;
    assign wr_go      = wr_valid & wr_ready;
    assign wr_go_data = wr_data;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (start)                 state_next = ST_LOAD;
                else if (wr_go && wr_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            wr_addr_reg <= '0;
            ram_rw      <= RW_READ;
            ram_addr    <= '0;
            ram_din     <= '0;
            done        <= 1'b0;
        end else begin
            state_reg <= state_next;
            done      <= wr_go & wr_last;

            if (start)
                wr_addr_reg <= '0;
            else if (wr_go)
                wr_addr_reg <= wr_last ? '0 : wr_addr_reg + 1'b1;

            if (rd_req) begin
                ram_rw   <= RW_READ;
                ram_addr <= rd_addr;
            end else if (wr_go) begin
                ram_rw   <= RW_WRITE;
                ram_addr <= wr_addr_reg;
                ram_din  <= wr_go_data;
            end else begin
                ram_rw   <= RW_READ;
            end
        end
    end

    // One stage for the registered address, one for the RAM's synchronous read.
    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    rd_pipe_reg[gi] <= 1'b0;
                else if (gi == 0)
                    rd_pipe_reg[gi] <= rd_req;
                else
                    rd_pipe_reg[gi] <= rd_pipe_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    assign rd_valid = rd_pipe_reg[RD_LATENCY-1];
    assign rd_data  = ram_dout;

endmodule

// File: tb/tb_img_ram_ctrl.sv
// Scoreboard bench for img_ram_ctrl with a behavioural single-port RAM; covers both builds
// (with and without IMG_RAM_SKID_EN).
module tb_img_ram_ctrl;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int NP = 4;
`ifdef IMG_RAM_SKID_EN
    localparam int DONE_LAT = 1;
`else
    localparam int DONE_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          start, wr_valid, wr_ready, rd_req, rd_valid;
    logic [DW-1:0] wr_data, rd_data, ram_din, ram_dout;
    logic [AW-1:0] rd_addr, ram_addr;
    logic          ram_rw, busy, done;

    logic [DW-1:0] mem   [0:(1<<AW)-1];
    logic [DW-1:0] model [0:NP-1];

    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    rq[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    img_ram_ctrl #(
        .AddressWidth(AW),
        .DataWidth   (DW),
        .NumPixels   (NP)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .ram_rw  (ram_rw),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_dout(ram_dout),
        .busy    (busy),
        .done    (done)
    );

    // Single-port RAM, 1-cycle synchronous read.
    always @(posedge clk) begin
        if (ram_rw) ram_dout <= mem[ram_addr];
        else        mem[ram_addr] <= ram_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write and every read result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (ram_rw === 1'b0) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write", ram_addr, ram_din);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = wq.pop_front();
                    $display("write addr=%0h data=%0h", ram_addr, ram_din);
                    check("write_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
                    check("write_data", 32'(ram_din), 32'(e[DW-1:0]));
                end
            end
            if (rd_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_read: actual data=%0h required no rd_valid", rd_data);
                end else begin
                    logic [DW-1:0] e;
                    e = rq.pop_front();
                    $display("read data=%0h", rd_data);
                    check("read_data", 32'(rd_data), 32'(e));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        check("start_blocks_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [AW-1:0] a);
        int k;
        k = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && k < 20) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            k++;
        end
        check("beat_accepted", 32'(wr_ready), 32'd1);
        if (wr_ready) begin
            wq.push_back({a, d});
            model[a] = d;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        rq.push_back(model[a]);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 10) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            k++;
        end
        check("done_latency", 32'(k), 32'(DONE_LAT));
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < NP; i++) model[i] = '0;
        rstn = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ram_rw", 32'(ram_rw), 32'd1);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        wr_valid = 1'b1;
        idle(2);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;

        // Full frame load
        pulse_start();
        @(negedge clk);
        check("load_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        send_beat(8'h11, 0);
        send_beat(8'h22, 1);
        send_beat(8'h33, 2);
        send_beat(8'h44, 3);
        wait_done();
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        repeat (2) begin
            @(negedge clk);
            check("extra_beat_ready", 32'(wr_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        check("frame_writes_seen", 32'(wq.size()), 32'd0);

        // Back-to-back reads of the frame, then a single read with latency checks
        for (int i = 0; i < NP; i++) begin
            issue_read(AW'(i));
            idle(1);
        end
        rd_req = 1'b0;
        idle(3);
        mem[5] = 8'hAB;
        issue_read(AW'(5));
        rq.pop_back();
        rq.push_back(8'hAB);
        @(negedge clk);
        check("lat_t0", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        check("lat_t1", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_t2_valid", 32'(rd_valid), 32'd1);
        check("lat_t2_data", 32'(rd_data), 32'hAB);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_t3", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reader priority over a pending beat
        pulse_start();
`ifdef IMG_RAM_SKID_EN
        issue_read(1);
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        @(negedge clk);
        check("skid_ready_during_read", 32'(wr_ready), 32'd1);
        check("prio_rw0", 32'(ram_rw), 32'd1);
        wq.push_back({AW'(0), 8'h5A});
        model[0] = 8'h5A;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        issue_read(2);
        @(negedge clk);
        check("skid_full_ready", 32'(wr_ready), 32'd0);
        check("prio_rw1", 32'(ram_rw), 32'd1);
        @(posedge clk);
        #1;
        issue_read(3);
        @(negedge clk);
        check("prio_rw2", 32'(ram_rw), 32'd1);
        check("prio_rd_valid", 32'(rd_valid), 32'd1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        check("prio_rw_release", 32'(ram_rw), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("held_beat_written", 32'(ram_rw), 32'd0);
        @(posedge clk);
        #1;
        send_beat(8'h98, 1);
        // A buffered beat is discarded by start
        issue_read(1);
        wr_valid = 1'b1;
        wr_data  = 8'h66;
        @(negedge clk);
        check("flush_beat_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        pulse_start();
        idle(3);
        check("flush_no_write", 32'(wq.size()), 32'd0);
`else
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            issue_read(AW'(i + 1));
            @(negedge clk);
            check("prio_wr_ready", 32'(wr_ready), 32'd0);
            check("prio_ram_rw", 32'(ram_rw), 32'd1);
            check("prio_rd_valid", 32'(rd_valid), (i == 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        @(negedge clk);
        check("release_wr_ready", 32'(wr_ready), 32'd1);
        wq.push_back({AW'(0), 8'h99});
        model[0] = 8'h99;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("held_beat_written", 32'(ram_rw), 32'd0);
        @(posedge clk);
        #1;
        send_beat(8'h98, 1);
`endif

        // Restart mid-load: addressing begins again at 0 and a full frame is needed for done
        pulse_start();
        send_beat(8'h77, 0);
        send_beat(8'h78, 1);
        send_beat(8'h79, 2);
        @(negedge clk);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_no_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        send_beat(8'h7A, 3);
        wait_done();
        issue_read(0);
        idle(1);
        issue_read(3);
        idle(1);
        rd_req = 1'b0;
        idle(4);
        check("writes_drained", 32'(wq.size()), 32'd0);
        check("reads_drained", 32'(rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
